// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI register-write initiator
package spi_pkg;

  localparam int SPI_FRAME_W = 16;

  localparam logic [6:0] SPI_ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] SPI_ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] SPI_ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] SPI_ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] SPI_ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  function automatic logic [SPI_FRAME_W-1:0] spi_frame(
    input logic       rw,
    input logic [6:0] addr,
    input logic [7:0] wdata
  );
    return {rw, addr, wdata};
  endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// rtl/spi_sclk_tick.sv - one-cycle tick every CLK_DIV clocks while enabled
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Down-counter parked at RELOAD while cleared, so the first tick lands CLK_DIV cycles after enable.
  assign tick = en && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= RELOAD;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_q <= RELOAD;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - mode-0 SPI initiator for 16-bit register-write frames
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       cipo,
  output logic       sclk,
  output logic       copi,
  output logic       cs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  spi_state_t             state_q, state_d;
  logic [SPI_FRAME_W-1:0] tx_q, tx_d;
  logic [7:0]             rx_q, rx_d;
  logic [4:0]             bit_q, bit_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_q, cs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   tick;

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  assign sclk  = sclk_q;
  assign copi  = tx_q[SPI_FRAME_W-1];
  assign cs    = cs_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = spi_frame(rw, addr, wdata);
          rx_d    = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], cipo};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // bit_q is the bit currently on the wire; the low half after bit 0's fall ends the phase.
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[SPI_FRAME_W-2:0], 1'b0};
          end else if (bit_q == 5'd15) begin
            state_d = HOLD;
          end else begin
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], cipo};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_d    = 1'b1;
          bit_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        // Two ticks of cs high; bit_q[0] marks the second half.
        if (tick) begin
          if (bit_q[0]) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rdata_d = rx_q;
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed self-checking bench for spi_controller
module tb_spi_controller;
  import spi_pkg::*;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic       cipo = 1'b0;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       sclk, copi, cs, busy, done;
  logic [7:0] rdata;

  int errors = 0;
  int checks = 0;

  spi_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .cipo  (cipo),
    .sclk  (sclk),
    .copi  (copi),
    .cs    (cs),
    .busy  (busy),
    .done  (done),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  // Pin monitor, register-peripheral model and mode-0 cipo target, all sampled on the falling clk edge.
  int          cyc = 0;
  logic        sclk_p = 1'b0, cs_p = 1'b1;
  logic [15:0] mon_frame = '0;
  logic [15:0] tgt_word = 16'hC33C;
  logic [15:0] tgt_sreg = '0;
  int mon_rises = 0, rise0_cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, gap_cyc = 0;
  int done_cyc = 0, done_cnt = 0, cs_fall_cnt = 0, sclk_bad = 0;
  logic [7:0] regs [0:4];

  always @(negedge clk) begin
    cyc++;
    if (!cs && cs_p) begin
      gap_cyc     = cyc - cs_rise_cyc;
      cs_fall_cyc = cyc;
      cs_fall_cnt++;
      mon_rises   = 0;
      mon_frame   = '0;
      tgt_sreg    = tgt_word;
      cipo        = tgt_sreg[15];
    end
    if (sclk !== sclk_p && cs && cs_p) sclk_bad++;
    if (sclk && !sclk_p) begin
      if (mon_rises == 0) rise0_cyc = cyc;
      mon_frame = {mon_frame[14:0], copi};
      mon_rises++;
    end
    if (!sclk && sclk_p) begin
      tgt_sreg = {tgt_sreg[14:0], 1'b0};
      cipo     = tgt_sreg[15];
    end
    if (cs && !cs_p) begin
      cs_rise_cyc = cyc;
      if (mon_rises == 16 && mon_frame[15] && mon_frame[14:8] <= 7'd4)
        regs[int'(mon_frame[14:8])] = mon_frame[7:0];
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    sclk_p = sclk;
    cs_p   = cs;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic r, input logic [6:0] a, input logic [7:0] d);
    rw = r; addr = a; wdata = d; start = 1'b1;
    step(1);
    start = 1'b0; rw = 1'b0; addr = 7'h55; wdata = 8'h99;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    step(3);
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (copi !== 1'b0) begin errors++; $display("FAIL reset_copi: got %b want 0", copi); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", cs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_frame;
    bit ok;
    int a;
    a = cyc;
    send(1'b1, SPI_ADDR_EN_OUT_7_0, 8'hA5);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_done_timeout: got none want done"); end
    checks++; if (mon_frame !== 16'h80A5) begin errors++; $display("FAIL frame_copi: got %h want 80a5", mon_frame); end
    checks++; if (mon_rises != 16) begin errors++; $display("FAIL frame_rises: got %0d want 16", mon_rises); end
    checks++; if (cs_fall_cyc - a != 1) begin errors++; $display("FAIL frame_cs_fall: got %0d want 1", cs_fall_cyc - a); end
    checks++; if (rise0_cyc - cs_fall_cyc != 4) begin errors++; $display("FAIL frame_first_rise: got %0d want 4", rise0_cyc - cs_fall_cyc); end
    checks++; if (cs_rise_cyc - cs_fall_cyc != 136) begin errors++; $display("FAIL frame_cs_low: got %0d want 136", cs_rise_cyc - cs_fall_cyc); end
    checks++; if (done_cyc - a != 145) begin errors++; $display("FAIL frame_done_time: got %0d want 145", done_cyc - a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_at_done: got %b want 0", busy); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL frame_rdata: got %h want 3c", rdata); end
    step(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b want 0", done); end
  endtask

  task automatic test_loopback;
    bit ok;
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
    send(1'b1, SPI_ADDR_PWM_DUTY, 8'h80);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop1_timeout: got none want done"); end
    checks++; if (regs[4] !== 8'h80) begin errors++; $display("FAIL loop1_pwm_duty: got %h want 80", regs[4]); end
    send(1'b1, SPI_ADDR_EN_PWM_7_0, 8'hFF);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop2_timeout: got none want done"); end
    checks++; if (regs[2] !== 8'hFF) begin errors++; $display("FAIL loop2_en_pwm: got %h want ff", regs[2]); end
    checks++; if (regs[4] !== 8'h80) begin errors++; $display("FAIL loop2_pwm_duty: got %h want 80", regs[4]); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) continue;
      checks++; if (regs[i] !== 8'h00) begin errors++; $display("FAIL loop_other_reg%0d: got %h want 00", i, regs[i]); end
    end
  endtask

  task automatic test_ignore;
    bit ok;
    int fc, dc;
    fc = cs_fall_cnt; dc = done_cnt;
    send(1'b1, SPI_ADDR_EN_PWM_15_8, 8'h12);
    step(40);
    rw = 1'b1; addr = SPI_ADDR_EN_OUT_15_8; wdata = 8'h77; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout: got none want done"); end
    checks++; if (mon_frame !== 16'h8312) begin errors++; $display("FAIL ignore_frame: got %h want 8312", mon_frame); end
    step(20);
    checks++; if (cs_fall_cnt - fc != 1) begin errors++; $display("FAIL ignore_frames: got %0d want 1", cs_fall_cnt - fc); end
    checks++; if (done_cnt - dc != 1) begin errors++; $display("FAIL ignore_dones: got %0d want 1", done_cnt - dc); end
    checks++; if (regs[1] !== 8'h00) begin errors++; $display("FAIL ignore_reg1: got %h want 00", regs[1]); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int dc;
    dc = done_cnt;
    send(1'b1, SPI_ADDR_EN_PWM_7_0, 8'h5A);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mon_rises == 8) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_bit7_timeout: got %0d rises want 8", mon_rises); end
    rst = 1'b1;
    step(1);
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rstmid_cs: got %b want 1", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b want 0", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    step(200);
    checks++; if (done_cnt != dc) begin errors++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, dc); end
    checks++; if (regs[2] !== 8'hFF) begin errors++; $display("FAIL rstmid_no_write: got %h want ff", regs[2]); end
    send(1'b0, SPI_ADDR_PWM_DUTY, 8'hC3);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_fresh_timeout: got none want done"); end
    checks++; if (mon_frame !== 16'h04C3) begin errors++; $display("FAIL rstmid_fresh_frame: got %h want 04c3", mon_frame); end
    checks++; if (mon_rises != 16) begin errors++; $display("FAIL rstmid_fresh_rises: got %0d want 16", mon_rises); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL rstmid_fresh_rdata: got %h want 3c", rdata); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int fc;
    rw = 1'b1; addr = SPI_ADDR_EN_OUT_7_0; wdata = 8'h11; start = 1'b1;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got none want done"); end
    fc = cs_fall_cnt;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (cs_fall_cnt != fc) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: got none want cs fall"); end
    checks++; if (gap_cyc != 2 * CLK_DIV + 1) begin errors++; $display("FAIL b2b_cs_gap: got %0d want %0d", gap_cyc, 2 * CLK_DIV + 1); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got none want done"); end
    checks++; if (mon_frame !== 16'h8011) begin errors++; $display("FAIL b2b_frame: got %h want 8011", mon_frame); end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
    test_reset();
    test_frame();
    test_loopback();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    step(20);
    checks++; if (sclk_bad != 0) begin errors++; $display("FAIL sclk_while_cs_high: got %0d want 0", sclk_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI initiator that serialises 16-bit register-write frames onto `sclk`/`copi`/`cs` for the on-chip SPI register peripheral (addresses 0x00–0x04: output enables, PWM enables, PWM duty cycle). It sits between a host-side request port (test logic or a sequencer) and the SPI pins. The frame format is mode 0, MSB first, `cs` active low. It also shifts in `cipo` and returns the low data byte for readback-capable targets.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period. Legal range is ≥ 2. It must be ≥ 4 when driving a peripheral that double-synchronises `sclk` on the same `clk`.
- `clk` input, 1: system clock; all logic is on the rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `start` input, 1: request strobe, sampled only when `busy` = 0.
- `rw` input, 1: frame bit 15; 1 = write.
- `addr` input, 7: frame bits 14:8.
- `wdata` input, 8: frame bits 7:0.
- `cipo` input, 1: serial data from the target.
- `sclk` output, 1: SPI clock, idle low.
- `copi` output, 1: serial data to the target.
- `cs` output, 1: chip select, active low, idle high.
- `busy` output, 1: a frame is in progress.
- `done` output, 1: one-cycle pulse at the end of a frame.
- `rdata` output, 8: last 8 `cipo` bits of the most recent frame.

## Operation
- Reset values: `sclk` = 0, `copi` = 0, `cs` = 1, `busy` = 0, `done` = 0, `rdata` = 0. The FSM goes to IDLE and the counters clear. Reset mid-frame aborts the frame on the next edge; there is no partial-frame completion and no `done` pulse.
- **IDLE:** if `start` is high, latch `{rw, addr, wdata}` into the 16-bit shift register, set `busy` = 1, drive `cs` = 0, put bit 15 on `copi`, and go to SETUP.
- **SETUP:** `cs` low, `sclk` low for `CLK_DIV` cycles, then go to SHIFT.
- **SHIFT:** 16 bits. Each bit is `sclk` high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - On the rising `sclk` transition, sample `cipo` into the receive shift register.
  - On the falling transition, advance `copi` to the next bit. After bit 0's falling transition, go to HOLD.
- **HOLD:** `sclk` low, `cs` low for `CLK_DIV` cycles, then `cs` = 1 and go to GAP.
- **GAP:** `cs` high for `2*CLK_DIV` cycles. On exit, pulse `done` for one cycle, drop `busy`, load `rdata` from the receive register bits 7:0, and return to IDLE.
- `start` while `busy` = 1 is ignored; it is not queued. Input fields are don't-care outside the acceptance cycle.
- The bit counter is 5 bits and counts 0–15 with no wrap past 15. The divider counter is `$clog2(CLK_DIV)` bits and reloads at `CLK_DIV-1`.

## Timing
- Let T0 be the edge that accepts `start`. `cs` falls and `copi` = bit 15 from T0+1.
- `sclk` rising edge n (n = 0..15) at T0+1+`CLK_DIV`·(1+2n). Falling edge n at T0+1+`CLK_DIV`·(2+2n).
- `copi` is stable for ≥ `CLK_DIV` cycles on each side of every `sclk` rising edge.
- `cs` rises at T0+1+34·`CLK_DIV`.
- `done` = 1 and `busy` = 0 during the cycle after edge T0+1+36·`CLK_DIV`; `rdata` is valid from the same edge.
- Back-to-back: `start` high during the `done` cycle is accepted. GAP guarantees `cs` high ≥ 2·`CLK_DIV` cycles between frames.
- Exactly 16 `sclk` rising edges occur per frame. `sclk` never toggles while `cs` = 1.

## Structure
- Package `spi_pkg`:
  - `SPI_FRAME_W` = 16.
  - Register address constants `SPI_ADDR_EN_OUT_7_0` = 0x00 through `SPI_ADDR_PWM_DUTY` = 0x04.
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
- Sub-module `spi_sclk_tick`: parameterised by `CLK_DIV`, with synchronous clear. It emits a one-cycle `tick` every `CLK_DIV` cycles while enabled. The FSM advances phases only on `tick`.

## Test plan
- `CLK_DIV` = 4, `rw`=1, `addr`=0x00, `wdata`=0xA5 → `copi` sampled at 16 `sclk` rises reads 0x80A5; `cs` low exactly 34·4+... = 136 cycles; `done` at T0+145.
- Loopback into the SPI register peripheral (same `clk`): writes `addr` 0x04 = 0x80, then `addr` 0x02 = 0xFF → `pwm_duty_cycle` = 0x80 and `en_reg_pwm_7_0` = 0xFF after the respective `done`; other registers stay 0.
- `start` pulsed again mid-frame with `addr`=0x01 → ignored; only one frame is observed, and it carries the original fields.
- `rst` asserted during SHIFT bit 7 → next edge `cs`=1, `sclk`=0, `busy`=0, no `done`; a fresh `start` afterwards produces a full, correct frame.
- `start` held high continuously → consecutive frames with `cs` high exactly 2·`CLK_DIV`+1 cycles between them.
- `cipo` driven from a model shifting 0x3C in mode 0 → `rdata` = 0x3C at `done`; 0 before the first frame.
